// File: rtl/mem_arbiter_pkg.sv
// Shared defines for the memory arbiter: data width, grant tags, FSM states.
package mem_arbiter_pkg;

    localparam int XLEN_DEF = 32;

    typedef enum logic [1:0] {
        TAG_NONE = 2'd0,
        TAG_IF   = 2'd1,
        TAG_D    = 2'd2,
        TAG_DMA  = 2'd3
    } tag_t;

    typedef enum logic {
        ST_ARB  = 1'b0,
        ST_LOCK = 1'b1
    } state_t;

endpackage

// File: rtl/arb_starve_cnt.sv
// Saturating count of cycles the DMA port has waited without a grant.
module arb_starve_cnt #(
    parameter int LIMIT = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clr,
    output logic full
);

    localparam int W = $clog2(LIMIT + 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && cnt != W'(LIMIT)) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign full = (cnt == W'(LIMIT));

endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter for fetch, data and DMA requesters.
// Define MEM_ARBITER_DMA_EN to enable the DMA port, starvation override and burst lock.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int XLEN         = XLEN_DEF,
    parameter int STARVE_LIMIT = 8,
    parameter int LOCK_MAX     = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            if_req,
    input  logic [XLEN-1:0] if_addr,
    output logic            if_gnt,
    output logic            if_rvalid,
    output logic [XLEN-1:0] if_rdata,
    input  logic            d_req,
    input  logic [XLEN-1:0] d_addr,
    input  logic [XLEN-1:0] d_wdata,
    input  logic [3:0]      d_wea,
    output logic            d_gnt,
    output logic            d_rvalid,
    output logic [XLEN-1:0] d_rdata,
    input  logic            dma_req,
    input  logic            dma_lock,
    input  logic [XLEN-1:0] dma_addr,
    input  logic [XLEN-1:0] dma_wdata,
    input  logic [3:0]      dma_wea,
    output logic            dma_gnt,
    output logic            dma_rvalid,
    output logic [XLEN-1:0] dma_rdata,
    output logic            mem_en,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    output logic [3:0]      mem_wea,
    input  logic [XLEN-1:0] mem_rdata,
    output logic            stall_core
);

    localparam int LW = $clog2(LOCK_MAX + 1);

    state_t          state, state_nxt;
    logic [LW-1:0]   lock_cnt, lock_nxt;
    tag_t            tag, tag_nxt;
    logic [XLEN-1:0] rdata_q, rdata_out;
    logic            starve_full;
    logic            dma_on;

`ifdef MEM_ARBITER_DMA_EN
    localparam bit DMA_EN = 1'b1;

    arb_starve_cnt #(
        .LIMIT(STARVE_LIMIT)
    ) u_starve (
        .clk  (clk),
        .rst  (rst),
        .inc  (dma_req && !dma_gnt),
        .clr  (dma_gnt),
        .full (starve_full)
    );
`else
    localparam bit DMA_EN = 1'b0;

    assign starve_full = 1'b0;
`endif

    assign dma_on = DMA_EN && dma_req;

    always_comb begin
        d_gnt     = 1'b0;
        if_gnt    = 1'b0;
        dma_gnt   = 1'b0;
        state_nxt = state;
        lock_nxt  = lock_cnt;
        unique case (state)
            ST_ARB: begin
                if (dma_on && starve_full) dma_gnt = 1'b1;
                else if (d_req)            d_gnt   = 1'b1;
                else if (if_req)           if_gnt  = 1'b1;
                else if (dma_on)           dma_gnt = 1'b1;
                // The granting cycle counts as the first locked cycle
                if (dma_gnt && dma_lock && LOCK_MAX > 1) begin
                    state_nxt = ST_LOCK;
                    lock_nxt  = LW'(1);
                end
            end
            ST_LOCK: begin
                dma_gnt  = dma_on;
                lock_nxt = lock_cnt + 1'b1;
                if (!dma_lock || lock_nxt == LW'(LOCK_MAX)) begin
                    state_nxt = ST_ARB;
                end
            end
        endcase
    end

    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        mem_wea   = '0;
        unique case (1'b1)
            d_gnt: begin
                mem_addr  = d_addr;
                mem_wdata = d_wdata;
                mem_wea   = d_wea;
            end
            if_gnt: begin
                mem_addr  = if_addr;
            end
            dma_gnt: begin
                mem_addr  = dma_addr;
                mem_wdata = dma_wdata;
                mem_wea   = dma_wea;
            end
            default: begin
                mem_addr  = '0;
            end
        endcase
    end

    assign mem_en     = d_gnt || if_gnt || dma_gnt;
    assign stall_core = (d_req && !d_gnt) || (if_req && !if_gnt);

    always_comb begin
        tag_nxt = TAG_NONE;
        if (d_gnt && d_wea == 4'b0)        tag_nxt = TAG_D;
        else if (if_gnt)                   tag_nxt = TAG_IF;
        else if (dma_gnt && dma_wea == 4'b0) tag_nxt = TAG_DMA;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_ARB;
            lock_cnt <= '0;
            tag      <= TAG_NONE;
        end else begin
            state    <= state_nxt;
            lock_cnt <= lock_nxt;
            tag      <= tag_nxt;
        end
    end

    // Read data path needs no reset; it only holds the last returned word
    always_ff @(posedge clk) begin
        if (tag != TAG_NONE) rdata_q <= mem_rdata;
    end

    assign rdata_out  = (tag != TAG_NONE) ? mem_rdata : rdata_q;
    assign if_rdata   = rdata_out;
    assign d_rdata    = rdata_out;
    assign dma_rdata  = DMA_EN ? rdata_out : '0;
    assign if_rvalid  = (tag == TAG_IF);
    assign d_rvalid   = (tag == TAG_D);
    assign dma_rvalid = DMA_EN && (tag == TAG_DMA);

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter; DMA scenarios follow MEM_ARBITER_DMA_EN.
module tb_mem_arbiter;

    localparam logic [2:0] G_0 = 3'b000;
    localparam logic [2:0] G_D = 3'b100;
    localparam logic [2:0] G_I = 3'b010;
    localparam logic [2:0] G_M = 3'b001;

`ifdef MEM_ARBITER_DMA_EN
    localparam bit DMA = 1'b1;
`else
    localparam bit DMA = 1'b0;
`endif

    typedef struct {
        int          cyc;
        logic [2:0]  gnt;
        logic        st;
        logic        en;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wea;
    } gexp_t;

    typedef struct {
        int          cyc;
        logic [2:0]  who;
        logic [31:0] data;
    } rexp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic        if_gnt, if_rvalid;
    logic [31:0] if_rdata;
    logic        d_req = 1'b0;
    logic [31:0] d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic [3:0]  d_wea = '0;
    logic        d_gnt, d_rvalid;
    logic [31:0] d_rdata;
    logic        dma_req = 1'b0;
    logic        dma_lock = 1'b0;
    logic [31:0] dma_addr = '0;
    logic [31:0] dma_wdata = '0;
    logic [3:0]  dma_wea = '0;
    logic        dma_gnt, dma_rvalid;
    logic [31:0] dma_rdata;
    logic        mem_en;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wea;
    logic [31:0] mem_rdata = '0;
    logic        stall_core;

    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    bit          chk_en = 1'b0;
    bit          have_last = 1'b0;
    logic [31:0] last = '0;
    gexp_t       exp_q[$];
    rexp_t       rd_q[$];

    mem_arbiter #(
        .XLEN(32), .STARVE_LIMIT(8), .LOCK_MAX(16)
    ) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_addr(d_addr), .d_wdata(d_wdata), .d_wea(d_wea),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .dma_req(dma_req), .dma_lock(dma_lock), .dma_addr(dma_addr),
        .dma_wdata(dma_wdata), .dma_wea(dma_wea), .dma_gnt(dma_gnt),
        .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
        .mem_en(mem_en), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wea(mem_wea), .mem_rdata(mem_rdata), .stall_core(stall_core)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] fmem(input logic [31:0] a);
        return a ^ 32'hA5A5_5A5A;
    endfunction

    // Memory model: read data valid the cycle after the command
    always @(posedge clk) begin
        if (mem_en && mem_wea == 4'b0) mem_rdata <= fmem(mem_addr);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s cyc=%0d actual=%h required=%h", nm, cyc, act, req);
        end
    endtask

    task automatic step(input logic [2:0] g, input logic st, input bit kill = 1'b0);
        gexp_t e;
        rexp_t r;
        e.cyc = cyc; e.gnt = g; e.st = st; e.en = (g != G_0);
        e.addr = '0; e.wdata = '0; e.wea = '0;
        if (g == G_D) begin
            e.addr = d_addr; e.wdata = d_wdata; e.wea = d_wea;
        end else if (g == G_I) begin
            e.addr = if_addr;
        end else if (g == G_M) begin
            e.addr = dma_addr; e.wdata = dma_wdata; e.wea = dma_wea;
        end
        exp_q.push_back(e);
        if (e.en && e.wea == 4'b0 && !kill) begin
            r.cyc = cyc + 1; r.who = g; r.data = fmem(e.addr);
            rd_q.push_back(r);
        end
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        gexp_t e;
        rexp_t r;
        if (chk_en) begin
            if (exp_q.size() != 0 && exp_q[0].cyc == cyc) begin
                e = exp_q.pop_front();
                chk("grant", 32'({d_gnt, if_gnt, dma_gnt}), 32'(e.gnt));
                chk("stall_core", 32'(stall_core), 32'(e.st));
                chk("mem_en", 32'(mem_en), 32'(e.en));
                chk("mem_wea", 32'(mem_wea), 32'(e.wea));
                if (e.en) chk("mem_addr", mem_addr, e.addr);
                if (e.wea != 4'b0) chk("mem_wdata", mem_wdata, e.wdata);
            end
            r.cyc = cyc; r.who = G_0; r.data = '0;
            if (rd_q.size() != 0 && rd_q[0].cyc == cyc) r = rd_q.pop_front();
            chk("rvalid", 32'({d_rvalid, if_rvalid, dma_rvalid}), 32'(r.who));
            if (r.who == G_D) chk("d_rdata", d_rdata, r.data);
            if (r.who == G_I) chk("if_rdata", if_rdata, r.data);
            if (r.who == G_M) chk("dma_rdata", dma_rdata, r.data);
            if (r.who != G_0) begin
                last = r.data;
                have_last = 1'b1;
            end else if (have_last) begin
                chk("d_rdata_hold", d_rdata, last);
                chk("if_rdata_hold", if_rdata, last);
                chk("dma_rdata_hold", dma_rdata, DMA ? last : 32'h0);
            end
        end
    end

    task automatic idle_in();
        if_req = 1'b0; d_req = 1'b0; dma_req = 1'b0; dma_lock = 1'b0;
        d_wea = '0; dma_wea = '0;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk_en = 1'b1;

        // Reset state, no requests
        step(G_0, 1'b0);

        // Data beats fetch, fetch stalls then goes next cycle
        d_req = 1'b1; d_addr = 32'h100; d_wea = 4'b0;
        if_req = 1'b1; if_addr = 32'h200;
        step(G_D, 1'b1);
        d_req = 1'b0;
        step(G_I, 1'b0);
        idle_in();
        step(G_0, 1'b0);
        step(G_0, 1'b0);

        // Partial write: no read-valid afterwards
        d_req = 1'b1; d_addr = 32'h40; d_wdata = 32'hDEAD_BEEF; d_wea = 4'b0011;
        step(G_D, 1'b0);
        idle_in();
        step(G_0, 1'b0);

        // Write plus fetch
        d_req = 1'b1; d_addr = 32'h44; d_wdata = 32'h1234_5678; d_wea = 4'b1111;
        if_req = 1'b1; if_addr = 32'h204;
        step(G_D, 1'b1);
        d_req = 1'b0; d_wea = 4'b0;
        step(G_I, 1'b0);

        // Back-to-back fetches
        for (int i = 0; i < 4; i++) begin
            if_addr = 32'h300 + 32'(4 * i);
            step(G_I, 1'b0);
        end
        idle_in();
        step(G_0, 1'b0);

`ifndef MEM_ARBITER_DMA_EN
        dma_req = 1'b1; dma_lock = 1'b1; dma_addr = 32'h500;
        step(G_0, 1'b0);
        d_req = 1'b1;
        for (int i = 0; i < 10; i++) begin
            d_addr = 32'h600 + 32'(4 * i);
            step(G_D, 1'b0);
        end
        d_req = 1'b0; if_req = 1'b1; if_addr = 32'h680;
        step(G_I, 1'b0);
        idle_in();
        step(G_0, 1'b0);
`else
        // Starvation: eight denied cycles, forced grant on the ninth
        dma_req = 1'b1; dma_addr = 32'h700; dma_wea = 4'b0;
        d_req = 1'b1; d_wea = 4'b0;
        for (int i = 0; i < 8; i++) begin
            d_addr = 32'h1000 + 32'(4 * i);
            step(G_D, 1'b0);
        end
        d_addr = 32'h1100;
        step(G_M, 1'b1);
        d_addr = 32'h1104;
        step(G_D, 1'b0);
        idle_in();
        step(G_0, 1'b0);

        // Locked burst capped at 16 cycles
        dma_req = 1'b1; dma_lock = 1'b1; dma_addr = 32'h800;
        step(G_M, 1'b0);
        d_req = 1'b1; d_addr = 32'h900;
        for (int i = 1; i < 16; i++) begin
            dma_addr = 32'h800 + 32'(4 * i);
            step(G_M, 1'b1);
        end
        for (int i = 16; i < 20; i++) begin
            dma_addr = 32'h800 + 32'(4 * i);
            d_addr = 32'h900 + 32'(4 * i);
            step(G_D, 1'b0);
        end
        idle_in();
        step(G_0, 1'b0);

        // Reset while locked with a DMA read in flight
        dma_req = 1'b1; dma_lock = 1'b1; dma_addr = 32'hA00;
        step(G_M, 1'b0);
        dma_addr = 32'hA04; rst = 1'b1;
        step(G_M, 1'b0, 1'b1);
        rst = 1'b0;
        d_req = 1'b1; d_addr = 32'hB00; d_wea = 4'b0;
        step(G_D, 1'b0);
        idle_in();
        step(G_0, 1'b0);
`endif

        step(G_0, 1'b0);
        step(G_0, 1'b0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
